// File: rtl/bka_seq_add.sv
// bka_seq_add: byte-serial adder/subtractor. Each operation is processed one
// byte per clock, LSB byte first, through a single 8-bit Brent-Kung prefix
// slice. The byte carry is held in a register between passes.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid / in_ready request handshake (accepted only in IDLE)
//   a, b, cin, sub      operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready result handshake (held in DONE until taken)
//   sum, cout, ovf      result, carry-out (sub: 1 = no borrow), signed overflow
//   busy                byte passes in progress

// 8-bit Brent-Kung carry slice with carry-in.
// c7 is the carry into bit 7 and co the carry out of bit 7; the top module
// XORs them on the last byte to get signed overflow.
module bka_slice8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       c7,
  output logic       co
);
  logic [7:0] g, p;
  logic [7:0] gp, pp; // group generate/propagate for bits [i:0]
  logic g32, p32, g54, p54, g76, p76, g74, p74;
  logic [8:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // up-sweep
  assign gp[0] = g[0];
  assign pp[0] = p[0];
  assign gp[1] = g[1] | (p[1] & g[0]);
  assign pp[1] = p[1] & p[0];
  assign g32   = g[3] | (p[3] & g[2]);
  assign p32   = p[3] & p[2];
  assign g54   = g[5] | (p[5] & g[4]);
  assign p54   = p[5] & p[4];
  assign g76   = g[7] | (p[7] & g[6]);
  assign p76   = p[7] & p[6];
  assign gp[3] = g32 | (p32 & gp[1]);
  assign pp[3] = p32 & pp[1];
  assign g74   = g76 | (p76 & g54);
  assign p74   = p76 & p54;
  assign gp[7] = g74 | (p74 & gp[3]);
  assign pp[7] = p74 & pp[3];

  // down-sweep fills in the remaining prefixes
  assign gp[5] = g54 | (p54 & gp[3]);
  assign pp[5] = p54 & pp[3];
  assign gp[2] = g[2] | (p[2] & gp[1]);
  assign pp[2] = p[2] & pp[1];
  assign gp[4] = g[4] | (p[4] & gp[3]);
  assign pp[4] = p[4] & pp[3];
  assign gp[6] = g[6] | (p[6] & gp[5]);
  assign pp[6] = p[6] & pp[5];

  // fold the slice carry-in in as a final prefix stage
  assign c[0]   = ci;
  assign c[8:1] = gp | (pp & {8{ci}});

  assign s  = p ^ c[7:0];
  assign c7 = c[7];
  assign co = c[8];
endmodule

module bka_seq_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NBYTES = WIDTH / 8;
  localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  generate
    if ((WIDTH < 8) || (WIDTH % 8 != 0)) begin : g_width_chk
      $error("bka_seq_add: WIDTH must be a multiple of 8 and at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [KW-1:0]    k_q;
  logic [KW+2:0]    base;
  logic [7:0]       sa, sb, ss;
  logic             sc7, sco;
  logic             last;

  assign base = {k_q, 3'b000};
  assign sa   = a_q[base +: 8];
  assign sb   = b_q[base +: 8];
  assign last = (k_q == KW'(NBYTES - 1));

  bka_slice8 u_slice (
    .x  (sa),
    .y  (sb),
    .ci (carry_q),
    .s  (ss),
    .c7 (sc7),
    .co (sco)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // retirement goes through IDLE, so no accept can share this edge
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // subtract as a + ~b + 1
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            k_q     <= '0;
          end
        end
        BUSY: begin
          sum_q[base +: 8] <= ss;
          carry_q          <= sco;
          k_q              <= k_q + 1'b1;
          if (last) begin
            cout_q <= sco;
            ovf_q  <= sc7 ^ sco;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bka_seq_add.sv
// Self-checking bench for bka_seq_add (WIDTH=32): directed corner cases plus
// random operations, scoreboarded against an arithmetic reference model.
module tb_bka_seq_add;
  localparam int W = 32;
  localparam int NB = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0;
  logic          cin = 1'b0, sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout, ovf, busy;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   rand_rdy = 0;

  bka_seq_add #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W:0] t;
    res_t r;
    if (sb) t = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else    t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    r.s = t[W-1:0];
    r.c = t[W];
    if (sb) r.v = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    else    r.v = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  // wait (bounded) for a negedge with in_ready, then present one op
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(x, y, ci, sb));
    acc_q.push_back(cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'd1);
  endtask

  // monitor: latency on out_valid rise, scoreboard pop on handshake
  initial begin
    bit prev_ov = 0;
    res_t e;
    int t0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        chk("one_hot_state", 64'(int'(in_ready) + int'(busy) + int'(out_valid)), 64'd1);
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
          else begin
            t0 = acc_q.pop_front();
            chk("latency", 64'(cyc - t0), 64'(NB));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("sum", 64'(sum), 64'(e.s));
            chk("cout", 64'(cout), 64'(e.c));
            chk("ovf", 64'(ovf), 64'(e.v));
          end
        end
      end
      prev_ov = out_valid && rst_n;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    res_t e;
    int n;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    mon_en = 1;
    out_ready = 1'b1;

    // directed corner cases
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    issue(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
    wait_idle();

    // stall in DONE with in_valid and changing operands
    out_ready = 1'b0;
    e = model(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0);
    issue(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_sum", 64'(sum), 64'(e.s));
      chk("stall_flags", 64'({cout, ovf}), 64'({e.c, e.v}));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("retire_in_ready", 64'(in_ready), 64'd1);
    chk("retire_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("no_second_accept", 64'(busy), 64'd0);

    // reset while BUSY with k=2
    issue(32'hCAFE_F00D, 32'h0101_0101, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy_ov", 64'({busy, out_valid}), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout_ovf", 64'({cout, ovf}), 64'd0);
    repeat (6) @(negedge clk);
    chk("midrst_no_result", 64'(out_valid), 64'd0);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_idle();

    // random operations with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 200; i++)
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rand_rdy = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bka_seq_add.md
BKA_SEQ_ADD -- requirements
Module: bka_seq_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are multiples of 8 and at least 8.
REQ-002 The block SHALL have derived constant NBYTES = WIDTH/8, meaning the number of byte-slice passes per operation.
REQ-003 The block SHALL have one clock and a synchronous active-low reset, with ports as follows:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used for add only.
- sub  input  1  selects the operation: 0 = A+B+cin, 1 = A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  operation in progress.

Function
REQ-004 The block SHALL compute all results with a single internal 8-bit parallel-prefix (Brent-Kung style) slice with carry-in, reused for every byte pass.
REQ-005 The block SHALL implement three states:
- IDLE: in_ready=1, busy=0, out_valid=0.
- BUSY: in_ready=0, busy=1, out_valid=0.
- DONE: in_ready=0, busy=0, out_valid=1.
REQ-006 An operation SHALL be accepted only on a rising edge with in_valid=1 in IDLE; in_valid in BUSY or DONE SHALL be ignored.
REQ-007 On acceptance the block SHALL:
- latch a;
- latch b, inverted when sub=1;
- set carry = (sub ? 1 : cin);
- clear byte index k to 0;
- go to BUSY.
REQ-008 On each BUSY edge the block SHALL:
- add byte k of the latched A and B with carry;
- write the 8-bit result into sum[8k+7:8k];
- update carry with the slice carry-out;
- increment k.
REQ-009 Processing SHALL be strictly LSB byte first.
REQ-010 On the edge that processes byte NBYTES-1 the block SHALL:
- set cout = final slice carry-out;
- set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
- go to DONE.
REQ-011 out_valid SHALL rise exactly NBYTES rising edges after the accepting edge (4 edges for WIDTH=32).
REQ-012 In DONE, sum, cout and ovf SHALL remain stable until out_valid=1 and out_ready=1 on a rising edge; the block then goes to IDLE.
REQ-013 Back-to-back accept SHALL NOT occur on the same edge as result retirement; in_ready SHALL be 1 from the cycle after retirement.
REQ-014 sum, cout and ovf SHALL hold their last values in IDLE and SHALL be undefined-for-use while busy=1.
REQ-015 The byte index k SHALL be wide enough for NBYTES; the NBYTES=1 case SHALL take 1 edge in BUSY.
REQ-016 A simultaneous in_valid and out_ready SHALL have no effect outside their own states.
REQ-017 All arithmetic SHALL be modulo 2^WIDTH; WIDTH not a multiple of 8 SHALL be flagged by an elaboration-time check.

Reset
REQ-018 When rst_n=0 at a rising edge, in any state including mid-BUSY, the block SHALL go to IDLE with:
- in_ready=1, busy=0, out_valid=0;
- sum=0, cout=0, ovf=0;
- carry=0, k=0.
REQ-019 Any in-flight operation SHALL be discarded by reset, and no out_valid pulse SHALL be produced for it.

Verification (WIDTH=32)
REQ-020 The bench SHALL cover: add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 edges after accept.
REQ-021 The bench SHALL cover: add a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-022 The bench SHALL cover: sub a=0x00000005, b=0x00000007 (cin=1 ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0; then sub a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-023 The bench SHALL cover: add a=0x000000FF, b=0, cin=1 -> sum=0x00000100, so the carry crosses the byte-0/byte-1 boundary.
REQ-024 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE with in_valid=1 and changing a/b -> sum/cout/ovf and out_valid stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
REQ-025 The bench SHALL cover: rst_n=0 for one edge while BUSY with k=2 -> next cycle IDLE with all outputs 0; a following add 0x12345678+0x11111111 -> sum=0x23456789, cout=0.
